// File: rtl/uart_img_writer.sv
// -----------------------------------------------------------------------------
// uart_img_writer
//
// Image loader placed directly upstream of the single-port image RAM. It waits
// for a frame-sync byte from the UART receiver, then writes the next ImageBytes
// bytes to RAM addresses 0, 1, 2, ... The RAM port is shared. A pending write
// strobe takes the port for one cycle. At all other times the VGA read address
// passes straight through.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   rx_data   in   [DataWidth]    byte from the UART receiver
//   rx_valid  in   one-cycle strobe, rx_data valid
//   rd_addr   in   [AddressWidth] VGA pixel-fetch address
//   ram_rw    out  1 = read, 0 = write
//   ram_addr  out  [AddressWidth] RAM address (write address or rd_addr)
//   ram_data  out  [DataWidth]    RAM write data
//   busy      out  frame load in progress
//   done      out  one-cycle pulse together with the last byte's write strobe
//   error     out  sticky timeout flag, cleared by the next sync byte
// -----------------------------------------------------------------------------
module uart_img_writer #(
    parameter int                   AddressWidth  = 14,
    parameter int                   DataWidth     = 8,
    parameter int                   ImageBytes    = 16384,
    parameter logic [DataWidth-1:0] SyncByte      = 8'hA5,
    parameter int                   TimeoutCycles = 1200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DataWidth-1:0]    rx_data,
    input  logic                    rx_valid,
    input  logic [AddressWidth-1:0] rd_addr,
    output logic                    ram_rw,
    output logic [AddressWidth-1:0] ram_addr,
    output logic [DataWidth-1:0]    ram_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int TmoWidth = $clog2(TimeoutCycles + 1);

    // Index of the final byte of a frame.
    localparam logic [AddressWidth:0] LastIdx = (AddressWidth + 1)'(ImageBytes - 1);
    // The counter holds the number of empty cycles already seen. When the
    // current cycle is also empty and the count reaches TimeoutCycles-1, this
    // cycle is the TimeoutCycles-th empty cycle.
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);
    localparam logic [TmoWidth-1:0] TmoMax  = TmoWidth'(TimeoutCycles);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [AddressWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0]    wr_data_q, wr_data_d;
    logic [AddressWidth:0]   wr_ptr_q, wr_ptr_d;
    logic [TmoWidth-1:0]     tmo_q, tmo_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        tmo_d     = tmo_q;
        done_d    = 1'b0;
        error_d   = error_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SyncByte)) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    tmo_d    = '0;
                    error_d  = 1'b0;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    // An arriving byte takes priority over a timeout in the same cycle.
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q[AddressWidth-1:0];
                    wr_data_d = rx_data;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    tmo_d     = '0;
                    if (wr_ptr_q == LastIdx) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (tmo_q == TmoLast) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (tmo_q != TmoMax) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // RAM port mux. The write strobe pre-empts VGA reads for one cycle.
    assign ram_rw   = ~wr_en_q;
    assign ram_addr = wr_en_q ? wr_addr_q : rd_addr;
    assign ram_data = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_uart_img_writer.sv
// -----------------------------------------------------------------------------
// tb_uart_img_writer
//
// Testbench for uart_img_writer with ImageBytes=4 and TimeoutCycles=10.
// The stimulus side models the loader and pushes each expected write onto a
// queue. The negedge monitor pops one entry for every write strobe it sees and
// compares them. A behavioural RAM with a registered read lets the bench read
// the frame back through rd_addr.
// -----------------------------------------------------------------------------
module tb_uart_img_writer;

    localparam int          AW   = 14;
    localparam int          DW   = 8;
    localparam int          NB   = 4;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic [DW-1:0] rx_data  = '0;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] rd_addr  = 14'h0123;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          busy;
    logic          done;
    logic          error;

    uart_img_writer #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .ImageBytes   (NB),
        .SyncByte     (SYNC),
        .TimeoutCycles(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_addr  (rd_addr),
        .ram_rw   (ram_rw),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with a registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (ram_rw == 1'b0) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t          sb[$];
    logic [DW-1:0] exp_mem [0:NB-1];
    bit           in_load = 0;
    int           ptr     = 0;
    wr_t          mon_e;

    // Drive one byte for one cycle and record the write the loader should make.
    task automatic send_byte(input logic [7:0] b);
        wr_t item;
        rx_data  = b;
        rx_valid = 1'b1;
        if (!in_load) begin
            if (b == SYNC) begin
                in_load = 1;
                ptr     = 0;
            end
        end else begin
            item.addr = AW'(ptr);
            item.data = b;
            item.last = (ptr == NB - 1);
            sb.push_back(item);
            exp_mem[ptr] = b;
            ptr++;
            if (ptr == NB) in_load = 0;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic readback();
        for (int i = 0; i < NB; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            check("rd_passthru", ram_addr, AW'(i));
            @(posedge clk);
            #1;
            check("rd_data", ram_q, exp_mem[i]);
            $display("RD addr=%0h data=%0h", i, ram_q);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_rw === 1'b0) begin
                $display("WR addr=%0h data=%0h done=%0b busy=%0b", ram_addr, ram_data, done, busy);
                if (sb.size() == 0) begin
                    check("unexpected_wr", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_addr", ram_addr, mon_e.addr);
                    check("wr_data", ram_data, mon_e.data);
                    check("wr_done", done, mon_e.last);
                    check("wr_busy", busy, !mon_e.last);
                end
            end else if (done !== 1'b0) begin
                check("done_nowr", done, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rw",    ram_rw,   1);
        check("rst_addr",  ram_addr, 14'h0123);
        check("rst_data",  ram_data, 0);
        check("rst_busy",  busy,     0);
        check("rst_done",  done,     0);
        check("rst_error", error,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Non-sync bytes in IDLE are discarded
        send_byte(8'h11);
        @(negedge clk);
        check("ign_rw",   ram_rw, 1);
        check("ign_busy", busy,   0);
        @(posedge clk);
        #1;
        send_byte(8'h22);
        @(negedge clk);
        check("ign_rw",   ram_rw, 1);
        check("ign_busy", busy,   0);
        @(posedge clk);
        #1;

        // Full frame, back-to-back. The embedded A5 is data.
        send_byte(SYNC);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(SYNC);
        send_byte(8'h44);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("frame_sb", sb.size(), 0);
        check("frame_busy", busy, 0);
        readback();

        // Timeout: error rises after 10 empty cycles
        send_byte(SYNC);
        send_byte(8'h77);
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("tmo_busy_pre",  busy,  1);
        check("tmo_error_pre", error, 0);
        @(negedge clk);
        check("tmo_busy",  busy,  0);
        check("tmo_error", error, 1);
        in_load = 0;
        @(posedge clk);
        #1;
        send_byte(SYNC);
        @(negedge clk);
        check("sync_clr_error", error, 0);
        check("sync_busy",      busy,  1);

        // Timeout race: the byte arrives on the 10th cycle of the gap
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        send_byte(8'h5A);
        @(negedge clk);
        check("race_error", error, 0);
        check("race_busy",  busy,  1);
        @(posedge clk);
        #1;

        // Reset while a write strobe is pending
        rd_addr  = 14'h0042;
        rx_data  = 8'h66;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("pend_rw",   ram_rw,   0);
        check("pend_addr", ram_addr, 1);
        rst = 1'b1;
        #1;
        check("midrst_rw",    ram_rw,   1);
        check("midrst_addr",  ram_addr, 14'h0042);
        check("midrst_busy",  busy,     0);
        check("midrst_done",  done,     0);
        check("midrst_error", error,    0);
        in_load = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // The next frame starts again at address 0
        send_byte(SYNC);
        send_byte(8'h21);
        send_byte(8'h32);
        send_byte(8'h43);
        send_byte(8'h54);
        @(negedge clk);
        @(posedge clk);
        #1;
        readback();

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_img_writer.md
# uart_img_writer

Image loader stage that sits directly upstream of the image RAM in the VGA image receiver. It consumes bytes from the UART receiver, waits for a frame-sync byte, then writes the following `ImageBytes` bytes sequentially into the RAM starting at address 0. It owns the RAM's single port and multiplexes it between these write strobes and the VGA read address. It flags a completed frame with `done` and an aborted frame with `error`.

## Interface

Parameters:
- `AddressWidth`, 14: RAM address width.
- `DataWidth`, 8: byte width. The RAM word width equals this.
- `ImageBytes`, 16384: bytes per frame. Legal range 1 to 2**AddressWidth.
- `SyncByte`, 8'hA5: frame-start marker.
- `TimeoutCycles`, 1200000: maximum idle gap between bytes inside a frame (100 ms at 12 MHz). Must be at least 2.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. Asynchronous, active-high.
- `rx_data` input DataWidth: byte from the UART receiver.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rd_addr` input AddressWidth: VGA pixel-fetch address.
- `ram_rw` output 1: to the RAM. 1 means read, 0 means write.
- `ram_addr` output AddressWidth: to the RAM address.
- `ram_data` output DataWidth: to the RAM write data.
- `busy` output 1: frame load in progress.
- `done` output 1: one-cycle pulse when the last byte of a frame is written.
- `error` output 1: sticky; set on timeout, cleared by the next sync byte or by reset.

## Operation

State machine with two states, IDLE and LOAD.

IDLE:
- `rx_valid` with `rx_data == SyncByte`: go to LOAD. Set `wr_ptr` to 0, clear the timeout counter, clear `error`.
- Any other byte is discarded with no RAM write.

LOAD:
- Each `rx_valid` registers a write: `wr_en_q=1`, `wr_addr_q=wr_ptr`, `wr_data_q=rx_data`. Then `wr_ptr` increments and the timeout counter clears.
- Bytes equal to `SyncByte` are ordinary data in this state.
- When the accepted byte is number `ImageBytes-1`, counting from 0:
  - go to IDLE;
  - `done` pulses one cycle, in the same cycle as that byte's write strobe.
- If no `rx_valid` arrives for `TimeoutCycles` consecutive cycles:
  - go to IDLE and set `error`;
  - `done` is not pulsed;
  - bytes already written stay in the RAM.

Arithmetic and widths:
- `wr_ptr` is AddressWidth+1 bits wide. It never wraps, because the frame ends at `ImageBytes-1`.
- The timeout counter saturates and is sized to ceil(log2(TimeoutCycles+1)) bits.

RAM port mux (combinational from registered state):
- `ram_rw = ~wr_en_q`.
- `ram_addr = wr_en_q ? wr_addr_q : rd_addr`.
- `ram_data = wr_data_q`.
- `wr_en_q` is high for exactly one cycle per accepted byte. During that cycle VGA reads are pre-empted; the display tolerates this one-pixel glitch.

`busy` is registered and equals (state == LOAD).

## Timing

- Reset values: state IDLE, `wr_en_q=0`, `wr_addr_q=0`, `wr_data_q=0`, `wr_ptr=0`, `busy=0`, `done=0`, `error=0`. Therefore `ram_rw=1`, `ram_addr=rd_addr`, `ram_data=0`.
- Latency: `rx_valid` in cycle N gives `ram_rw=0` and address/data valid in cycle N+1. The RAM captures the write at the rising edge ending N+1.
- Back-to-back `rx_valid` on every cycle is supported, giving one write per cycle with no loss.
- Sync byte in cycle N: `busy=1` and `error=0` from cycle N+1.
- Last byte in cycle N: `done=1`, `busy=0`, and the final write strobe all occur in cycle N+1.
- Timeout: `busy` falls and `error` rises in the cycle after the TimeoutCycles-th empty cycle.
- If `rx_valid` arrives in the same cycle the timeout would fire, the byte wins: it is written and the counter clears.
- `rd_addr` to `ram_addr` is purely combinational with zero latency when no write is pending. RAM read data follows one cycle later, per the RAM.
- `rst` asserted mid-frame: all registers clear immediately (asynchronously). Any pending write strobe is dropped in the same instant. The frame is abandoned without `done` or `error`.

## Test plan

- Reset: hold `rst` with `rd_addr=0x0123` -> `ram_rw=1`, `ram_addr=0x0123`, `busy=0`, `done=0`, `error=0`.
- Non-sync ignore: in IDLE send 0x11, 0x22 -> `ram_rw` stays 1 and `busy` stays 0.
- Full frame with `ImageBytes=4`, back-to-back: send A5, 11, 22, A5, 44 ->
  - writes (addr, data) = (0,11), (1,22), (2,A5), (3,44) on consecutive cycles;
  - `done` high for exactly one cycle, with the write to address 3;
  - `busy` falls in that same cycle;
  - reading addresses 0..3 through `rd_addr` returns 11, 22, A5, 44.
- Timeout with `TimeoutCycles=10`: send A5, 77, then idle ->
  - one write (0,77);
  - `error=1` and `busy=0` after 10 empty cycles;
  - sending A5 again clears `error`.
- Timeout race: in LOAD, present `rx_valid` exactly on cycle 10 of the gap -> the byte is written, `error` stays 0.
- Reset mid-frame: assert `rst` in the same cycle as a pending write strobe -> `ram_rw` returns to 1 at once and `busy=0`. After release, the next frame starts again at address 0.
